// File: rtl/uart_frame_packer_if.sv
// uart_frame_packer_if: handshake and data bundle between the UART byte
// engines, the FPU and uart_frame_packer.
// FRAME_BYTES and RESULT_BYTES must match the packer instance's
// OPERAND_BYTES*NUM_OPERANDS and RESULT_BYTES.
// master: the surrounding system (RX engine, FPU, TX engine).
// slave:  the packer.
interface uart_frame_packer_if #(
  parameter int FRAME_BYTES  = 8,
  parameter int RESULT_BYTES = 4
);
  logic [7:0]                rx_byte;
  logic                      rx_valid;
  logic [FRAME_BYTES*8-1:0]  ops;
  logic                      ops_valid;
  logic                      ops_ready;
  logic [RESULT_BYTES*8-1:0] res;
  logic                      res_valid;
  logic                      res_ready;
  logic [7:0]                tx_byte;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      overrun;
  logic                      busy;

  modport master (
    output rx_byte, rx_valid, ops_ready, res, res_valid, tx_ready,
    input  ops, ops_valid, res_ready, tx_byte, tx_valid, overrun, busy
  );

  modport slave (
    input  rx_byte, rx_valid, ops_ready, res, res_valid, tx_ready,
    output ops, ops_valid, res_ready, tx_byte, tx_valid, overrun, busy
  );
endinterface

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: collects a fixed-length frame of UART RX bytes into
// NUM_OPERANDS operands, hands them to the FPU, waits for the result and
// serialises the result back out to the UART TX engine.
// Optional feature macro: UART_FRAME_TIMEOUT_EN -- when defined, a partial
// frame is discarded after TIMEOUT_CYCLES idle cycles; when undefined a
// partial frame waits indefinitely and no counter is built.
module uart_frame_packer #(
  parameter int OPERAND_BYTES  = 4,
  parameter int NUM_OPERANDS   = 2,
  parameter int RESULT_BYTES   = 4,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                sys_clk,
  input logic                rst,
  uart_frame_packer_if.slave bus
);

  localparam int FRAME_BYTES = OPERAND_BYTES * NUM_OPERANDS;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int RES_W       = RESULT_BYTES * 8;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int TX_CNT_W    = $clog2(RESULT_BYTES + 1);

  localparam logic [1:0] ST_COLLECT  = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RES = 2'd2;
  localparam logic [1:0] ST_SEND     = 2'd3;

  logic [1:0]          state_reg;
  logic [CNT_W-1:0]    byte_cnt_reg;
  logic [FRAME_W-1:0]  shift_reg;
  logic [FRAME_W-1:0]  frame_next;
  logic [FRAME_W-1:0]  ops_reg;
  logic                ops_valid_reg;
  logic                res_ready_reg;
  logic [RES_W-1:0]    tx_shift_reg;
  logic [TX_CNT_W-1:0] tx_cnt_reg;
  logic                tx_valid_reg;
  logic                overrun_reg;
  logic                last_byte;
  logic                timeout_hit;

  // Frame assembly: the shift register with the incoming byte merged in,
  // in wire order.
  if (MSB_FIRST != 0) begin : g_rx_msb
    assign frame_next = (shift_reg << 8) | FRAME_W'(bus.rx_byte);
  end else begin : g_rx_lsb
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_slot
      assign frame_next[gi*8 +: 8] = (byte_cnt_reg == CNT_W'(gi)) ? bus.rx_byte
                                                                  : shift_reg[gi*8 +: 8];
    end
  end

  assign last_byte = (byte_cnt_reg == CNT_W'(FRAME_BYTES - 1));

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            to_run;

  assign to_run      = (state_reg == ST_COLLECT) && !bus.rx_valid && (byte_cnt_reg != '0);
  assign timeout_hit = to_run && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter; held at zero outside a partial frame so it
  // starts fresh on every byte and on every return to COLLECT.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg <= '0;
    end else if (to_run && !timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end else begin
      to_cnt_reg <= '0;
    end
  end
`else
  // Without the timeout a partial frame never expires; the parameter only
  // has to be legal.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES < 0);
`endif

  // Main control: frame collection, FPU handshakes, result serialisation
  // and the sticky overrun flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_COLLECT;
      byte_cnt_reg  <= '0;
      shift_reg     <= '0;
      ops_reg       <= '0;
      ops_valid_reg <= 1'b0;
      res_ready_reg <= 1'b0;
      tx_shift_reg  <= '0;
      tx_cnt_reg    <= '0;
      tx_valid_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      // A byte arriving while a transaction is in flight cannot be stored.
      if (bus.rx_valid && (state_reg != ST_COLLECT)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_COLLECT: begin
          if (bus.rx_valid) begin
            shift_reg <= frame_next;
            if (last_byte) begin
              byte_cnt_reg  <= '0;
              ops_reg       <= frame_next;
              ops_valid_reg <= 1'b1;
              state_reg     <= ST_ISSUE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            byte_cnt_reg <= '0;
          end
        end
        ST_ISSUE: begin
          // ops_valid is high throughout this state.
          if (bus.ops_ready) begin
            ops_valid_reg <= 1'b0;
            res_ready_reg <= 1'b1;
            state_reg     <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (bus.res_valid) begin
            tx_shift_reg  <= bus.res;
            tx_cnt_reg    <= '0;
            tx_valid_reg  <= 1'b1;
            res_ready_reg <= 1'b0;
            state_reg     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_valid is high throughout this state; shifting out also
          // leaves tx_byte at zero once the word is done.
          if (bus.tx_ready) begin
            tx_shift_reg <= (MSB_FIRST != 0) ? (tx_shift_reg << 8) : (tx_shift_reg >> 8);
            if (tx_cnt_reg == TX_CNT_W'(RESULT_BYTES - 1)) begin
              tx_cnt_reg   <= '0;
              tx_valid_reg <= 1'b0;
              state_reg    <= ST_COLLECT;
            end else begin
              tx_cnt_reg <= tx_cnt_reg + TX_CNT_W'(1);
            end
          end
        end
        default: state_reg <= ST_COLLECT;
      endcase
    end
  end

  // The byte on the wire is always the head of the TX shift register.
  if (MSB_FIRST != 0) begin : g_tx_msb
    assign bus.tx_byte = tx_shift_reg[RES_W-1 -: 8];
  end else begin : g_tx_lsb
    assign bus.tx_byte = tx_shift_reg[7:0];
  end

  assign bus.ops       = ops_reg;
  assign bus.ops_valid = ops_valid_reg;
  assign bus.res_ready = res_ready_reg;
  assign bus.tx_valid  = tx_valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.busy      = (state_reg != ST_COLLECT);

endmodule
